// File: rtl/vx_tcu_drl_exp_align.sv
// Exponent alignment stage for the TCU dot-product datapath: finds the maximum
// term exponent and derives a saturated per-term right shift, over two registered stages.
module vx_tcu_drl_exp_align #(
    parameter int N       = 2,
    parameter int TCK     = 2 * N,
    parameter int EXP_W   = 10,
    parameter int WA      = 28,
    parameter int SHIFT_W = $clog2(WA + 1),
    parameter int TAG_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [TAG_W-1:0]             tag_in,
    input  logic [(TCK+1)*EXP_W-1:0]     raw_exp_y,
    input  logic [TCK*6-1:0]             exp_diff_f8,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [TAG_W-1:0]             tag_out,
    output logic [EXP_W-1:0]             max_exp,
    output logic [(TCK+1)*SHIFT_W-1:0]   shift_amt,
    output logic [TCK*6-1:0]             exp_diff_f8_out,
    output logic                         all_zero
);

    localparam int NT = TCK + 1;
    localparam logic [EXP_W-1:0]   NEG_INF = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]   WA_E    = EXP_W'(WA);
    localparam logic [SHIFT_W-1:0] WA_S    = SHIFT_W'(WA);

    // Sentinel sorts below everything; all other exponents compare unsigned.
    function automatic logic exp_gt(input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b);
        return (a != NEG_INF) && ((b == NEG_INF) || (a > b));
    endfunction

    logic en;
    assign en       = ~valid_out | ready_out;
    assign ready_in = en;

    logic [EXP_W-1:0] max_next;
    logic             all_zero_next;

    always_comb begin
        max_next      = NEG_INF;
        all_zero_next = 1'b1;
        for (int i = 0; i < NT; i++) begin
            if (exp_gt(raw_exp_y[i*EXP_W +: EXP_W], max_next)) begin
                max_next = raw_exp_y[i*EXP_W +: EXP_W];
            end
            all_zero_next = all_zero_next & (raw_exp_y[i*EXP_W +: EXP_W] == NEG_INF);
        end
    end

    logic                      s1_valid_reg;
    logic [NT*EXP_W-1:0]       s1_exp_reg;
    logic [EXP_W-1:0]          s1_max_reg;
    logic                      s1_all_zero_reg;
    logic [TAG_W-1:0]          s1_tag_reg;
    logic [TCK*6-1:0]          s1_diff_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg    <= 1'b0;
            s1_exp_reg      <= '0;
            s1_max_reg      <= '0;
            s1_all_zero_reg <= 1'b0;
            s1_tag_reg      <= '0;
            s1_diff_reg     <= '0;
        end else if (en) begin
            s1_valid_reg    <= valid_in;
            s1_exp_reg      <= raw_exp_y;
            s1_max_reg      <= max_next;
            s1_all_zero_reg <= all_zero_next;
            s1_tag_reg      <= tag_in;
            s1_diff_reg     <= exp_diff_f8;
        end
    end

    // Non-sentinel terms never exceed the max, so the difference cannot go negative.
    logic [NT*SHIFT_W-1:0] shift_next;

    generate
        for (genvar gi = 0; gi < NT; gi++) begin : g_shift
            logic [EXP_W-1:0] term;
            logic [EXP_W-1:0] diff;
            assign term = s1_exp_reg[gi*EXP_W +: EXP_W];
            assign diff = s1_max_reg - term;
            assign shift_next[gi*SHIFT_W +: SHIFT_W] =
                ((term == NEG_INF) || s1_all_zero_reg || (diff >= WA_E)) ? WA_S : diff[SHIFT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out       <= 1'b0;
            tag_out         <= '0;
            max_exp         <= '0;
            shift_amt       <= '0;
            exp_diff_f8_out <= '0;
            all_zero        <= 1'b0;
        end else if (en) begin
            valid_out       <= s1_valid_reg;
            tag_out         <= s1_tag_reg;
            max_exp         <= s1_max_reg;
            shift_amt       <= shift_next;
            exp_diff_f8_out <= s1_diff_reg;
            all_zero        <= s1_all_zero_reg;
        end
    end

endmodule

// File: tb/tb_vx_tcu_drl_exp_align.sv
// Directed testbench for vx_tcu_drl_exp_align (N=2, TCK=4, EXP_W=10, WA=28).
module tb_vx_tcu_drl_exp_align;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  tag_in;
    logic [49:0] raw_exp_y;
    logic [23:0] exp_diff_f8;
    logic        valid_out;
    logic        ready_out;
    logic [7:0]  tag_out;
    logic [9:0]  max_exp;
    logic [24:0] shift_amt;
    logic [23:0] exp_diff_f8_out;
    logic        all_zero;

    int n_checks = 0;
    int n_fail   = 0;

    vx_tcu_drl_exp_align dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .tag_in(tag_in), .raw_exp_y(raw_exp_y), .exp_diff_f8(exp_diff_f8),
        .valid_out(valid_out), .ready_out(ready_out), .tag_out(tag_out),
        .max_exp(max_exp), .shift_amt(shift_amt), .exp_diff_f8_out(exp_diff_f8_out),
        .all_zero(all_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] pack_exp(input logic [9:0] c, input logic [9:0] t3,
                                             input logic [9:0] t2, input logic [9:0] t1,
                                             input logic [9:0] t0);
        return {c, t3, t2, t1, t0};
    endfunction

    function automatic logic [24:0] pack_sh(input logic [4:0] c, input logic [4:0] t3,
                                            input logic [4:0] t2, input logic [4:0] t1,
                                            input logic [4:0] t0);
        return {c, t3, t2, t1, t0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        tag_in = '0; raw_exp_y = '0; exp_diff_f8 = '0;
        #3;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_checks++; if (max_exp !== 10'd0) begin n_fail++; $display("FAIL reset_max: got %0d want 0", max_exp); end
        n_checks++; if (shift_amt !== 25'd0) begin n_fail++; $display("FAIL reset_shift: got %h want 0", shift_amt); end
        n_checks++; if (all_zero !== 1'b0) begin n_fail++; $display("FAIL reset_all_zero: got %b want 0", all_zero); end
        n_checks++; if (tag_out !== 8'd0 || exp_diff_f8_out !== 24'd0) begin n_fail++; $display("FAIL reset_passthru: tag %h diff %h want 0", tag_out, exp_diff_f8_out); end
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        tick();
        n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
        $display("reset: done");
    endtask

    // Presents one beat, checks the 2-cycle latency and the resulting outputs.
    task automatic run_beat(input string name, input logic [49:0] exps, input logic [7:0] tag,
                            input logic [23:0] diff, input logic [9:0] exp_max,
                            input logic [24:0] exp_sh, input logic exp_az);
        ready_out = 1'b1; valid_in = 1'b1; raw_exp_y = exps; tag_in = tag; exp_diff_f8 = diff;
        #1;
        n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL %s_ready_in: got %b want 1", name, ready_in); end
        tick();
        valid_in = 1'b0; raw_exp_y = '0; tag_in = '0; exp_diff_f8 = '0;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid: got %b want 0", name, valid_out); end
        tick();
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL %s_latency: valid_out got %b want 1", name, valid_out); end
        n_checks++; if (max_exp !== exp_max) begin n_fail++; $display("FAIL %s_max: got %h want %h", name, max_exp, exp_max); end
        n_checks++; if (shift_amt !== exp_sh) begin n_fail++; $display("FAIL %s_shift: got %h want %h", name, shift_amt, exp_sh); end
        n_checks++; if (all_zero !== exp_az) begin n_fail++; $display("FAIL %s_all_zero: got %b want %b", name, all_zero, exp_az); end
        n_checks++; if (tag_out !== tag || exp_diff_f8_out !== diff) begin n_fail++; $display("FAIL %s_passthru: tag %h diff %h want %h %h", name, tag_out, exp_diff_f8_out, tag, diff); end
        $display("%s: tag=%0d max=%h shift=%h all_zero=%b", name, tag_out, max_exp, shift_amt, all_zero);
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_single_beat: valid_out got %b want 0", name, valid_out); end
    endtask

    task automatic test_basic;
        run_beat("basic", pack_exp(10'd130, 10'd125, 10'd140, 10'd100, 10'd139), 8'hA1, 24'h123456,
                 10'd140, pack_sh(5'd10, 5'd15, 5'd0, 5'd28, 5'd1), 1'b0);
    endtask

    task automatic test_saturation;
        run_beat("saturation", pack_exp(10'h200, 10'd50, 10'd90, 10'd61, 10'h200), 8'hB2, 24'hABCDEF,
                 10'd90, pack_sh(5'd28, 5'd28, 5'd0, 5'd28, 5'd28), 1'b0);
    endtask

    task automatic test_all_zero;
        run_beat("all_zero", pack_exp(10'h200, 10'h200, 10'h200, 10'h200, 10'h200), 8'h5C, 24'hF0F0F0,
                 10'h200, pack_sh(5'd28, 5'd28, 5'd28, 5'd28, 5'd28), 1'b1);
    endtask

    // Beat k has term0 = 100+10k and the other four terms at 100.
    task automatic test_back_to_back;
        int sent, rcv, stall_left, e;
        logic first_seen;
        logic [7:0]  snap_tag;
        logic [9:0]  snap_max;
        logic [24:0] snap_sh;
        sent = 0; rcv = 0; stall_left = 0; first_seen = 1'b0;
        snap_tag = '0; snap_max = '0; snap_sh = '0;
        for (int cyc = 0; cyc < 60 && rcv < 5; cyc++) begin
            if (valid_out && !first_seen) begin
                first_seen = 1'b1; stall_left = 3;
                snap_tag = tag_out; snap_max = max_exp; snap_sh = shift_amt;
            end
            ready_out   = (stall_left == 0);
            valid_in    = (sent < 5);
            tag_in      = 8'(sent + 1);
            raw_exp_y   = pack_exp(10'd100, 10'd100, 10'd100, 10'd100, 10'(100 + 10 * (sent + 1)));
            exp_diff_f8 = 24'(sent + 1) * 24'h010101;
            #1;
            if (stall_left > 0) begin
                n_checks++; if (ready_in !== 1'b0) begin n_fail++; $display("FAIL stall_ready_in: got %b want 0", ready_in); end
                if (stall_left < 3) begin
                    n_checks++; if (valid_out !== 1'b1 || tag_out !== snap_tag || max_exp !== snap_max || shift_amt !== snap_sh) begin
                        n_fail++; $display("FAIL stall_hold: v=%b tag=%h max=%h sh=%h want 1 %h %h %h", valid_out, tag_out, max_exp, shift_amt, snap_tag, snap_max, snap_sh);
                    end
                end
                stall_left--;
            end
            if (valid_out && ready_out) begin
                e = (10 * (rcv + 1) > 28) ? 28 : 10 * (rcv + 1);
                n_checks++; if (tag_out !== 8'(rcv + 1)) begin n_fail++; $display("FAIL b2b_tag: got %0d want %0d", tag_out, rcv + 1); end
                n_checks++; if (max_exp !== 10'(100 + 10 * (rcv + 1))) begin n_fail++; $display("FAIL b2b_max: got %0d want %0d", max_exp, 100 + 10 * (rcv + 1)); end
                n_checks++; if (shift_amt !== pack_sh(5'(e), 5'(e), 5'(e), 5'(e), 5'd0)) begin n_fail++; $display("FAIL b2b_shift: got %h beat %0d", shift_amt, rcv + 1); end
                n_checks++; if (exp_diff_f8_out !== 24'(rcv + 1) * 24'h010101) begin n_fail++; $display("FAIL b2b_diff: got %h beat %0d", exp_diff_f8_out, rcv + 1); end
                $display("b2b: beat tag=%0d max=%0d shift=%h", tag_out, max_exp, shift_amt);
                rcv++;
            end
            if (valid_in && ready_in) sent++;
            tick();
        end
        valid_in = 1'b0; ready_out = 1'b1;
        n_checks++; if (rcv != 5 || sent != 5) begin n_fail++; $display("FAIL b2b_count: received %0d sent %0d want 5 5", rcv, sent); end
        n_checks++; if (!first_seen) begin n_fail++; $display("FAIL b2b_stall_seen: stall never started, want 1"); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate: valid_out got %b want 0", valid_out); end
    endtask

    task automatic test_reset_mid;
        ready_out = 1'b1;
        valid_in = 1'b1; tag_in = 8'h11; raw_exp_y = pack_exp(10'd200, 10'd190, 10'd180, 10'd170, 10'd160); exp_diff_f8 = 24'h111111;
        tick();
        tag_in = 8'h22; exp_diff_f8 = 24'h222222;
        tick();
        valid_in = 1'b0;
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: valid_out got %b want 1", valid_out); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", valid_out); end
        n_checks++; if (max_exp !== 10'd0 || shift_amt !== 25'd0 || all_zero !== 1'b0) begin n_fail++; $display("FAIL mid_async_data: max %h sh %h az %b want 0", max_exp, shift_amt, all_zero); end
        n_checks++; if (tag_out !== 8'd0 || exp_diff_f8_out !== 24'd0) begin n_fail++; $display("FAIL mid_async_passthru: tag %h diff %h want 0", tag_out, exp_diff_f8_out); end
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: valid_out got %b want 0", valid_out); end
        run_beat("post_reset", pack_exp(10'd120, 10'd120, 10'd120, 10'd120, 10'd120), 8'h33, 24'h333333,
                 10'd120, 25'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_all_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_tcu_drl_exp_align.md
Name: vx_tcu_drl_exp_align

Overview:
- Registered stage directly downstream of the TCU dot-product exponent/bias stage.
- Takes the TCK product exponents plus the C-term exponent (raw_exp_y, EXP_W bits each; sentinel EXP_NEG_INF marks zero/masked terms).
- Finds the maximum exponent and computes a saturated per-term right-shift amount for the significand aligner.
- Passes the fp8 packed exponent-difference bundle through unchanged.
- 2-stage valid/ready pipeline with full throughput and global stall.

Parameters:
- N, 2: input register pairs per row/column.
- TCK, 2*N: number of product terms (term index TCK is the C-term).
- EXP_W, 10: exponent width.
- WA, 28: accumulator alignment window width; shift saturation value.
- SHIFT_W, $clog2(WA+1): shift-amount width.
- TAG_W, 8: opaque sideband width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block can accept a beat.
- tag_in  in  TAG_W  sideband, passed through.
- raw_exp_y  in  (TCK+1)*EXP_W  term exponents; [TCK] is the C-term.
- exp_diff_f8  in  TCK*6  fp8 sub-pair diffs, passed through.
- valid_out  out  1  output beat valid.
- ready_out  in  1  consumer accepts.
- tag_out  out  TAG_W  delayed tag_in.
- max_exp  out  EXP_W  maximum non-sentinel exponent, or EXP_NEG_INF.
- shift_amt  out  (TCK+1)*SHIFT_W  per-term right shift.
- exp_diff_f8_out  out  TCK*6  delayed exp_diff_f8.
- all_zero  out  1  every term is the sentinel.

Behaviour:
- EXP_NEG_INF = {1'b1, (EXP_W-1) zeros}. It compares below every other value; all other values compare as unsigned.
- Pipeline enable: en = ~valid_out | ready_out. ready_in = en (combinational).
  - Both stages advance only when en = 1.
  - Stage valids shift: s1_valid <= valid_in; valid_out <= s1_valid.
  - Bubbles are not compressed.
- Stage 1 (registered): max-reduction tree over the TCK+1 terms using the sentinel-aware compare. Registers the inputs, the max, tag and exp_diff_f8. all_zero1 = AND over (term == sentinel).
- Stage 2 (registered): for each term i:
  - If term_i == sentinel, or all_zero1: shift_amt[i] = WA.
  - Otherwise d = max - term_i in EXP_W bits, never negative; shift_amt[i] = (d >= WA) ? WA : d[SHIFT_W-1:0].
- Latency: 2 cycles from an accepted input (valid_in & ready_in) to valid_out, with no stall. Throughput: 1 beat/cycle.
- Stall (valid_out = 1, ready_out = 0):
  - All output registers hold their values stable.
  - ready_in = 0; an input presented while stalled is not consumed.
  - valid_out stays 1 until the beat is accepted.
- valid_in = 0 while en = 1: a bubble propagates, so s1_valid becomes 0. Payload registers may update but are don't-care when their valid is 0.
- Reset (asynchronous, active-low, also mid-beat): all valids = 0, max_exp = 0, shift_amt = 0, all_zero = 0, tag_out = 0, exp_diff_f8_out = 0.
  - In-flight beats are dropped.
  - ready_in = 1 the cycle after reset releases.
- Ties: equal maxima produce shift 0 for every tied term.
- Sentinel C-term: the C-term is treated like any other term (shift WA).

Test Plan:
- Basic (TCK=4, WA=28): raw_exp_y = {C=130, 125, 140, 100, 139} -> max_exp = 140; shift_amt = {10, 15, 0, 28, 1}; valid_out exactly 2 cycles after acceptance; all_zero = 0.
- Saturation and sentinel: terms {0x200, 50, 90, 61, 0x200} -> max = 90; shifts {28, 28, 0, 28, 28} (40 saturates, 29 saturates, sentinels = 28).
- All zero: all terms 0x200 -> max_exp = 0x200, all_zero = 1, every shift = 28; tag and exp_diff_f8 pass through unchanged.
- Back-to-back with stall: 5 consecutive beats, ready_out held 0 for 3 cycles after the first valid_out.
  - Outputs stable during the stall; ready_in = 0 during the stall.
  - All 5 beats emerge in order with correct tags 1..5, with no loss or duplication.
- Reset mid-operation: assert reset low while 2 beats are in flight.
  - valid_out drops immediately (asynchronously); all outputs are 0.
  - After release, a new beat {120 x5} yields max = 120, shifts all 0, 2 cycles later.
